fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; directly upstream of decode and the stall unit.
- Consumes the stall unit's En (1 = advance, 0 = hold decode) and branch/jump redirects from later stages.
- Drives the multi-cycle instruction memory/cache with a level request held until Done.
- Presents DecInstruct and the PC+2 value to decode, with one outstanding memory request at most.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } fetchState_e;

  localparam instr_t     NOP_INSTR_DEF = 16'h0800;
  localparam logic [4:0] HALT_OPC_DEF  = 5'b00000;

  function automatic logic isHalt(input instr_t word, input logic [4:0] opc);
    return word[15:11] == opc;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus: level request held until done, one outstanding access.
interface fetch_stage_if;
  logic [15:0] IMemAddr;
  logic        IMemRd;
  logic [15:0] IMemData;
  logic        IMemDone;

  modport master (output IMemAddr, output IMemRd, input IMemData, input IMemDone);
  modport slave  (input IMemAddr, input IMemRd, output IMemData, output IMemDone);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter instr_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        stallBubble,
  input  instr_t      loadInstr,
  input  logic [15:0] loadPcPlus2,
  output instr_t      decInstruct,
  output logic [15:0] decPcPlus2,
  output logic        decValid,
  output logic        fetchStall
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decInstruct <= NOP_INSTR;
      decPcPlus2  <= 16'h0000;
      decValid    <= 1'b0;
      fetchStall  <= 1'b0;
    end else if (load) begin
      decInstruct <= loadInstr;
      decPcPlus2  <= loadPcPlus2;
      decValid    <= 1'b1;
      fetchStall  <= 1'b0;
    end else if (bubble) begin
      decInstruct <= NOP_INSTR;
      decValid    <= 1'b0;
      fetchStall  <= stallBubble;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch FSM and PC; feeds decode through fetch_stage_if_id_reg.
// Optional PREFETCH_BUF_EN adds a second holding entry filled while decode stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter instr_t      NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [4:0]  HALT_OPC  = HALT_OPC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         En,
  input  logic         Redirect,
  input  logic [15:0]  RedirectPC,
  fetch_stage_if.master imem,
  output instr_t       DecInstruct,
  output logic [15:0]  DecPCPlus2,
  output logic         DecValid,
  output logic         FetchStall
);

  fetchState_e state, stateNext;
  logic [15:0] pc, pcNext, pcPlus2, redirTarget, redirNext, redirPc;
  logic        squash, squashNext;
  instr_t      hold1, hold1Next;
  logic        rdReq, memDone;
  logic        decLoad, decBubble, decStallBubble;
  instr_t      decLoadInstr;
`ifdef PREFETCH_BUF_EN
  instr_t      hold2, hold2Next;
  logic        hold2Valid, hold2ValidNext;
`endif

  assign pcPlus2 = pc + 16'd2;
  assign redirPc = {RedirectPC[15:1], 1'b0};
  assign memDone = imem.IMemDone & rdReq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REQ;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= {RESET_PC[15:1], 1'b0};
      squash      <= 1'b0;
      redirTarget <= 16'h0000;
      hold1       <= NOP_INSTR;
`ifdef PREFETCH_BUF_EN
      hold2       <= NOP_INSTR;
      hold2Valid  <= 1'b0;
`endif
    end else begin
      pc          <= pcNext;
      squash      <= squashNext;
      redirTarget <= redirNext;
      hold1       <= hold1Next;
`ifdef PREFETCH_BUF_EN
      hold2       <= hold2Next;
      hold2Valid  <= hold2ValidNext;
`endif
    end
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    squashNext = squash;
    redirNext  = redirTarget;
    hold1Next  = hold1;
`ifdef PREFETCH_BUF_EN
    hold2Next      = hold2;
    hold2ValidNext = hold2Valid;
`endif
    if (Redirect) begin
`ifdef PREFETCH_BUF_EN
      hold2ValidNext = 1'b0;
`endif
      stateNext = REQ;
      if (rdReq && !memDone) begin
        // keep the outstanding address on the bus; the late word is dropped
        squashNext = 1'b1;
        redirNext  = redirPc;
`ifdef PREFETCH_BUF_EN
        if (state == FULL) pcNext = pcPlus2;
`endif
      end else begin
        squashNext = 1'b0;
        pcNext     = redirPc;
      end
    end else begin
      case (state)
        REQ: begin
          if (memDone) begin
            if (squash) begin
              squashNext = 1'b0;
              pcNext     = redirTarget;
            end else if (En) begin
              pcNext    = pcPlus2;
              stateNext = isHalt(imem.IMemData, HALT_OPC) ? HALTED : REQ;
            end else begin
              hold1Next = imem.IMemData;
              stateNext = FULL;
            end
          end
        end
        FULL: begin
`ifdef PREFETCH_BUF_EN
          if (En) begin
            pcNext = pcPlus2;
            if (isHalt(hold1, HALT_OPC)) begin
              stateNext = HALTED;
            end else if (hold2Valid) begin
              hold1Next      = hold2;
              hold2ValidNext = 1'b0;
            end else if (memDone) begin
              hold1Next = imem.IMemData;
            end else begin
              stateNext = REQ;
            end
          end else if (memDone) begin
            hold2Next      = imem.IMemData;
            hold2ValidNext = 1'b1;
          end
`else
          if (En) begin
            pcNext    = pcPlus2;
            stateNext = isHalt(hold1, HALT_OPC) ? HALTED : REQ;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdReq          = 1'b0;
    imem.IMemAddr  = pc;
    decLoad        = 1'b0;
    decBubble      = 1'b0;
    decStallBubble = 1'b0;
    decLoadInstr   = imem.IMemData;
    case (state)
      REQ: rdReq = rst;
      FULL: begin
        decLoadInstr = hold1;
`ifdef PREFETCH_BUF_EN
        rdReq         = rst & ~hold2Valid & ~isHalt(hold1, HALT_OPC);
        imem.IMemAddr = pcPlus2;
`endif
      end
      default: ;
    endcase
    if (Redirect) begin
      decBubble = 1'b1;
    end else if (En) begin
      case (state)
        REQ: begin
          if (memDone && !squash) begin
            decLoad = 1'b1;
          end else begin
            decBubble      = 1'b1;
            decStallBubble = 1'b1;
          end
        end
        FULL:    decLoad   = 1'b1;
        default: decBubble = 1'b1;
      endcase
    end
    imem.IMemRd = rdReq;
  end

  fetch_stage_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_ifId (
    .clk         (clk),
    .rst         (rst),
    .load        (decLoad),
    .bubble      (decBubble),
    .stallBubble (decStallBubble),
    .loadInstr   (decLoadInstr),
    .loadPcPlus2 (pcPlus2),
    .decInstruct (DecInstruct),
    .decPcPlus2  (DecPCPlus2),
    .decValid    (DecValid),
    .fetchStall  (FetchStall)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed decode and memory-bus expectations per cycle.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        En;
  logic        Redirect;
  logic [15:0] RedirectPC;
  instr_t      DecInstruct;
  logic [15:0] DecPCPlus2;
  logic        DecValid;
  logic        FetchStall;
  int          nCmp = 0;
  int          nErr = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .En         (En),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem       (imem),
    .DecInstruct(DecInstruct),
    .DecPCPlus2 (DecPCPlus2),
    .DecValid   (DecValid),
    .FetchStall (FetchStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, clock it, sample 1 time unit after the edge
  task automatic step(input logic en, input logic rd, input logic [15:0] rpc,
                      input logic done, input logic [15:0] data);
    En            = en;
    Redirect      = rd;
    RedirectPC    = rpc;
    imem.IMemDone = done;
    imem.IMemData = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chkDec(input string tag, input logic [15:0] ins, input logic [15:0] pcp,
                        input logic vld);
    chk({tag, ".instr"}, DecInstruct, ins);
    chk({tag, ".pcp2"}, DecPCPlus2, pcp);
    chk({tag, ".valid"}, {15'd0, DecValid}, {15'd0, vld});
  endtask

  task automatic chkBus(input string tag, input logic rd, input logic [15:0] addr);
    chk({tag, ".rd"}, {15'd0, imem.IMemRd}, {15'd0, rd});
    if (rd) chk({tag, ".addr"}, imem.IMemAddr, addr);
  endtask

  initial begin
    rst = 1'b0;
    En = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
    imem.IMemDone = 1'b0; imem.IMemData = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chkDec("reset", 16'h0800, 16'h0000, 1'b0);
    chk("reset.stall", {15'd0, FetchStall}, 16'd0);
    chk("reset.rd", {15'd0, imem.IMemRd}, 16'd0);
    rst = 1'b1;
    #1;
    chkBus("release", 1'b1, 16'h0000);

    // back-to-back same-cycle hits
    step(1, 0, 0, 1, 16'h4001);
    chkDec("hit1", 16'h4001, 16'h0002, 1'b1);
    chkBus("hit1", 1'b1, 16'h0002);
    step(1, 0, 0, 1, 16'h4002);
    chkDec("hit2", 16'h4002, 16'h0004, 1'b1);
    chkBus("hit2", 1'b1, 16'h0004);

    // decode stalled while word at 4 returns
    step(0, 0, 0, 1, 16'h4003);
    chkDec("full1", 16'h4002, 16'h0004, 1'b1);
    chkBus("full1", 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 16'hBEEF);
      chkDec("fullHold", 16'h4002, 16'h0004, 1'b1);
      chkBus("fullHold", 1'b0, 16'h0000);
    end
    step(1, 0, 0, 0, 16'hBEEF);
    chkDec("drain", 16'h4003, 16'h0006, 1'b1);
    chkBus("drain", 1'b1, 16'h0006);

    // memory wait: three bubbles then the word
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 16'hBEEF);
      chkDec("wait", 16'h0800, 16'h0006, 1'b0);
      chk("wait.stall", {15'd0, FetchStall}, 16'd1);
      chkBus("wait", 1'b1, 16'h0006);
    end
    step(1, 0, 0, 1, 16'h4004);
    chkDec("late", 16'h4004, 16'h0008, 1'b1);
    chk("late.stall", {15'd0, FetchStall}, 16'd0);
    chkBus("late", 1'b1, 16'h0008);

    // redirect with a request outstanding
    step(1, 1, 16'h0100, 0, 16'hBEEF);
    chk("sq1.valid", {15'd0, DecValid}, 16'd0);
    chk("sq1.instr", DecInstruct, 16'h0800);
    chkBus("sq1", 1'b1, 16'h0008);
    step(1, 0, 0, 0, 16'hBEEF);
    chk("sq2.valid", {15'd0, DecValid}, 16'd0);
    chkBus("sq2", 1'b1, 16'h0008);
    step(1, 0, 0, 1, 16'hDEAD);
    chk("sq3.valid", {15'd0, DecValid}, 16'd0);
    chk("sq3.instr", DecInstruct, 16'h0800);
    chkBus("sq3", 1'b1, 16'h0100);
    step(1, 0, 0, 1, 16'h4005);
    chkDec("tgt", 16'h4005, 16'h0102, 1'b1);
    chkBus("tgt", 1'b1, 16'h0102);

    // redirect while holding in FULL
    step(0, 0, 0, 1, 16'h4006);
    chkBus("full2", 1'b0, 16'h0000);
    chkDec("full2", 16'h4005, 16'h0102, 1'b1);
    step(0, 1, 16'h0200, 0, 16'hBEEF);
    chk("flush.valid", {15'd0, DecValid}, 16'd0);
    chk("flush.instr", DecInstruct, 16'h0800);
    chkBus("flush", 1'b1, 16'h0200);
    step(1, 0, 0, 1, 16'h4007);
    chkDec("afterFlush", 16'h4007, 16'h0202, 1'b1);

    // HALT word
    step(1, 0, 0, 1, 16'h0000);
    chkDec("halt", 16'h0000, 16'h0204, 1'b1);
    chkBus("halt", 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 16'hBEEF);
      chkDec("halted", 16'h0800, 16'h0204, 1'b0);
      chkBus("halted", 1'b0, 16'h0000);
    end
    step(1, 1, 16'h0020, 0, 16'hBEEF);
    chkBus("unhalt", 1'b1, 16'h0020);
    chk("unhalt.valid", {15'd0, DecValid}, 16'd0);
    step(1, 0, 0, 1, 16'h4008);
    chkDec("resume", 16'h4008, 16'h0022, 1'b1);

    // redirect with same-cycle done, odd target, PC wrap
    step(1, 1, 16'hFFFF, 1, 16'h1234);
    chkBus("toTop", 1'b1, 16'hFFFE);
    chk("toTop.valid", {15'd0, DecValid}, 16'd0);
    step(1, 0, 0, 1, 16'h4009);
    chkDec("wrap", 16'h4009, 16'h0000, 1'b1);
    chkBus("wrap", 1'b1, 16'h0000);

    // En=0 with no data: decode holds
    step(0, 0, 0, 0, 16'hBEEF);
    chkDec("holdReq", 16'h4009, 16'h0000, 1'b1);
    chkBus("holdReq", 1'b1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
